// File: rtl/_regfile8x16.sv
`default_nettype none
// ============================================================================
//  Module      : _regfile8x16
//  Description : Eight-entry, 16-bit register file with one synchronous write
//                port and two independent combinational read ports. First
//                storage stage of the datapath; feeds operands to the 16-bit
//                logic/mux layer.
//  Revision    : 1.0  - initial release
// ----------------------------------------------------------------------------
//  Ports
//     clk          in   1     single clock, rising edge active
//     reset        in   1     synchronous, active-high; clears all registers
//     in_data      in   [0:15] write data (bit 0 = MSB)
//     in_waddr     in   [0:2]  write address (bit 0 = MSB)
//     in_we        in   1     write enable
//     in_raddr_a   in   [0:2]  read address, port A (bit 0 = MSB)
//     in_raddr_b   in   [0:2]  read address, port B (bit 0 = MSB)
//     out_a        out  [0:15] register[in_raddr_a], combinational
//     out_b        out  [0:15] register[in_raddr_b], combinational
//  Configuration
//     REGFILE_BYPASS_EN  when defined, a write presented this cycle is
//                        forwarded to any read port addressing the same
//                        register (suppressed while reset is high).
// ============================================================================
module _regfile8x16 (
   input  logic        clk,
   input  logic        reset,
   input  logic [0:15] in_data,
   input  logic [0:2]  in_waddr,
   input  logic        in_we,
   input  logic [0:2]  in_raddr_a,
   input  logic [0:2]  in_raddr_b,
   output logic [0:15] out_a,
   output logic [0:15] out_b
);

   // Fixed geometry; deliberately not overridable.
   localparam int N     = 16;
   localparam int DEPTH = 8;

   logic [0:N-1]     r_regs [0:DEPTH-1];
   logic [0:N-1]     w_next [0:DEPTH-1];
   logic [DEPTH-1:0] w_wen;
   logic [0:2]       w_waddr_n;
   logic [0:N-1]     w_rd_a;
   logic [0:N-1]     w_rd_b;

   assign w_waddr_n = ~in_waddr;

   // ------------------------------------------------------------------------
   // Write decode (1-to-8 demux from AND/NOT gates) and per-register storage.
   // Each enable is the AND of the three true/complement address literals
   // matching that register's index, gated by in_we.
   // ------------------------------------------------------------------------
   generate
      for (genvar i = 0; i < DEPTH; i++) begin : g_reg
         localparam logic [2:0] c_sel = 3'(i);

         assign w_wen[i] = in_we
                         & (c_sel[2] ? in_waddr[0] : w_waddr_n[0])
                         & (c_sel[1] ? in_waddr[1] : w_waddr_n[1])
                         & (c_sel[0] ? in_waddr[2] : w_waddr_n[2]);

         // Per-bit load/hold mux in front of the flops.
         assign w_next[i] = w_wen[i] ? in_data : r_regs[i];

         // Reset has priority over any write in the same cycle.
         always_ff @(posedge clk) begin
            if (reset) begin
               r_regs[i] <= '0;
            end else begin
               r_regs[i] <= w_next[i];
            end
         end
      end
   endgenerate

   // ------------------------------------------------------------------------
   // Read ports: 8-way 16-bit muxes, no latency. Every 3-bit address is valid.
   // ------------------------------------------------------------------------
   assign w_rd_a = r_regs[in_raddr_a];
   assign w_rd_b = r_regs[in_raddr_b];

`ifdef REGFILE_BYPASS_EN
   logic w_byp_a;
   logic w_byp_b;

   // Write-through: forward in_data when this cycle's write targets the
   // register being read. Reset wins, so stored values are shown instead.
   assign w_byp_a = in_we & ~reset & (in_raddr_a == in_waddr);
   assign w_byp_b = in_we & ~reset & (in_raddr_b == in_waddr);

   assign out_a = w_byp_a ? in_data : w_rd_a;
   assign out_b = w_byp_b ? in_data : w_rd_b;
`else
   assign out_a = w_rd_a;
   assign out_b = w_rd_b;
`endif

endmodule
`default_nettype wire

// File: tb/tb__regfile8x16.sv
`default_nettype none
// ============================================================================
//  Module      : tb__regfile8x16
//  Description : Self-checking bench for _regfile8x16. Directed scenarios plus
//                randomized traffic compared against an array-based model of
//                the register file. Honours REGFILE_BYPASS_EN.
//  Revision    : 1.0  - initial release
// ============================================================================
module tb__regfile8x16;

   logic        clk;
   logic        reset;
   logic [0:15] in_data;
   logic [0:2]  in_waddr;
   logic        in_we;
   logic [0:2]  in_raddr_a;
   logic [0:2]  in_raddr_b;
   logic [0:15] out_a;
   logic [0:15] out_b;

   int n_checks;
   int n_fails;

   // Reference model: the eight registers as a plain array.
   logic [15:0] model [8];

   _regfile8x16 dut (
      .clk        (clk),
      .reset      (reset),
      .in_data    (in_data),
      .in_waddr   (in_waddr),
      .in_we      (in_we),
      .in_raddr_a (in_raddr_a),
      .in_raddr_b (in_raddr_b),
      .out_a      (out_a),
      .out_b      (out_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fails++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Value a read port should show during the current cycle.
   function automatic logic [15:0] expect_rd(input logic [2:0] addr);
`ifdef REGFILE_BYPASS_EN
      if (in_we && !reset && addr == 3'(in_waddr)) return in_data;
`endif
      return model[addr];
   endfunction

   // One clock cycle: drive inputs just after a rising edge, sample outputs
   // at the falling edge, then advance the model across the next rising edge.
   task automatic cycle(input logic rst, input logic we, input logic [2:0] wa,
                        input logic [15:0] wd, input logic [2:0] ra,
                        input logic [2:0] rb, input bit do_chk,
                        output logic [15:0] oa, output logic [15:0] ob);
      reset      = rst;
      in_we      = we;
      in_waddr   = wa;
      in_data    = wd;
      in_raddr_a = ra;
      in_raddr_b = rb;
      @(negedge clk);
      oa = out_a;
      ob = out_b;
      if (do_chk) begin
         check("port_a", oa, expect_rd(ra));
         check("port_b", ob, expect_rd(rb));
      end
      @(posedge clk);
      if (rst) begin
         for (int k = 0; k < 8; k++) model[k] = 16'h0000;
      end else if (we) begin
         model[wa] = wd;
      end
      #1;
   endtask

   initial begin
      logic [15:0] oa, ob;
      logic [15:0] v;
      n_checks = 0;
      n_fails  = 0;
      reset = 1'b1; in_we = 1'b0; in_waddr = '0; in_data = '0;
      in_raddr_a = '0; in_raddr_b = '0;
      @(posedge clk); #1;

      // Reset (contents unknown before it, so no check this cycle).
      cycle(1'b1, 1'b0, 3'd0, 16'h0, 3'd0, 3'd0, 1'b0, oa, ob);

      // Reset then read all.
      for (int i = 0; i < 8; i++) begin
         cycle(1'b0, 1'b0, 3'd0, 16'h0, 3'(i), 3'(7 - i), 1'b1, oa, ob);
         check("reset_zero_a", oa, 16'h0000);
         check("reset_zero_b", ob, 16'h0000);
      end

      // Write sweep.
      for (int i = 0; i < 8; i++) begin
         v = (i == 7) ? 16'hFFFF : 16'(16'h1111 * (i + 1));
         cycle(1'b0, 1'b1, 3'(i), v, 3'd0, 3'd7, 1'b1, oa, ob);
      end
      // Read A ascending, B descending.
      for (int i = 0; i < 8; i++) begin
         cycle(1'b0, 1'b0, 3'd0, 16'h0, 3'(i), 3'(7 - i), 1'b1, oa, ob);
      end
      cycle(1'b0, 1'b0, 3'd0, 16'h0, 3'd2, 3'd7, 1'b1, oa, ob);
      check("sweep_reg2", oa, 16'h3333);
      check("sweep_reg7", ob, 16'hFFFF);

      // Hold on we=0.
      for (int i = 0; i < 4; i++) begin
         cycle(1'b0, 1'b0, 3'd3, 16'hDEAD, 3'd3, 3'd3, 1'b1, oa, ob);
      end
      cycle(1'b0, 1'b0, 3'd0, 16'h0, 3'd3, 3'd3, 1'b1, oa, ob);
      check("hold_reg3", oa, 16'h4444);

      // Read-during-write on reg5.
      cycle(1'b0, 1'b1, 3'd5, 16'hBEEF, 3'd5, 3'd0, 1'b1, oa, ob);
`ifdef REGFILE_BYPASS_EN
      check("rdw_same_cycle", oa, 16'hBEEF);
`else
      check("rdw_same_cycle", oa, 16'h6666);
`endif
      cycle(1'b0, 1'b0, 3'd0, 16'h0, 3'd5, 3'd5, 1'b1, oa, ob);
      check("rdw_next_cycle", oa, 16'hBEEF);

      // Reset beats write.
      cycle(1'b1, 1'b1, 3'd2, 16'hA5A5, 3'd2, 3'd2, 1'b1, oa, ob);
      cycle(1'b0, 1'b0, 3'd0, 16'h0, 3'd2, 3'd5, 1'b1, oa, ob);
      check("reset_beats_write", oa, 16'h0000);
      check("reset_clears_reg5", ob, 16'h0000);

      // Dual-port same address and bit order.
      cycle(1'b0, 1'b1, 3'b100, 16'h8000, 3'd0, 3'd0, 1'b1, oa, ob);
      cycle(1'b0, 1'b0, 3'd0, 16'h0, 3'b100, 3'b100, 1'b1, oa, ob);
      check("dual_a", oa, 16'h8000);
      check("dual_b", ob, 16'h8000);
      check("msb_bit0", 16'(out_a[0]), 16'h0001);

      // Back-to-back writes to the same address.
      cycle(1'b0, 1'b1, 3'd6, 16'h1234, 3'd6, 3'd1, 1'b1, oa, ob);
      cycle(1'b0, 1'b1, 3'd6, 16'h5678, 3'd6, 3'd1, 1'b1, oa, ob);
`ifndef REGFILE_BYPASS_EN
      check("b2b_first_visible", oa, 16'h1234);
`endif
      cycle(1'b0, 1'b0, 3'd0, 16'h0, 3'd6, 3'd6, 1'b1, oa, ob);
      check("b2b_last_wins", oa, 16'h5678);

      // Randomized traffic.
      for (int t = 0; t < 400; t++) begin
         cycle(($urandom_range(0, 29) == 0), 1'($urandom), 3'($urandom),
               16'($urandom), 3'($urandom), 3'($urandom), 1'b1, oa, ob);
      end

      $display("%0d/%0d checks passed", n_checks - n_fails, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
